// File: rtl/lnet_pkg.sv
// Shared types, default widths and the reference feature quantizer for the layer0 input packer.
// Build macro LNET_PACK_ROUND_EN selects round-half-up with saturation instead of truncation.
package lnet_pkg;

    localparam int LNET_FEAT_W     = 8;
    localparam int LNET_QUANT_BITS = 2;

    typedef enum logic {
        FILL,
        HOLD
    } lnet_state_e;

    // Quantizer at the default widths; the sum is one bit wider than a feature so it cannot wrap.
    function automatic logic [LNET_QUANT_BITS-1:0] lnet_quant(input logic [LNET_FEAT_W-1:0] feature);
        localparam int SHIFT = LNET_FEAT_W - LNET_QUANT_BITS;
`ifdef LNET_PACK_ROUND_EN
        logic [LNET_QUANT_BITS:0] upper;
        upper = (LNET_QUANT_BITS+1)'(({1'b0, feature} + ((LNET_FEAT_W+1)'(1) << (SHIFT-1))) >> SHIFT);
        return upper[LNET_QUANT_BITS] ? {LNET_QUANT_BITS{1'b1}} : upper[LNET_QUANT_BITS-1:0];
`else
        return LNET_QUANT_BITS'(feature >> SHIFT);
`endif
    endfunction

endpackage

// File: rtl/lnet_feature_quant.sv
// Combinational FEAT_W -> QUANT_BITS feature quantizer (truncate, or round/saturate with LNET_PACK_ROUND_EN).
module lnet_feature_quant
    import lnet_pkg::*;
#(
    parameter int FEAT_W     = LNET_FEAT_W,
    parameter int QUANT_BITS = LNET_QUANT_BITS
) (
    input  logic [FEAT_W-1:0]     feature,
    output logic [QUANT_BITS-1:0] code
);

    localparam int SHIFT = FEAT_W - QUANT_BITS;

    // Default widths share the package function; other widths use the same arithmetic locally.
    generate
        if (FEAT_W == LNET_FEAT_W && QUANT_BITS == LNET_QUANT_BITS) begin : g_pkg
            assign code = lnet_quant(feature);
        end else begin : g_generic
`ifdef LNET_PACK_ROUND_EN
            logic [QUANT_BITS:0] upper;
            assign upper = (QUANT_BITS+1)'(({1'b0, feature} + ((FEAT_W+1)'(1) << (SHIFT-1))) >> SHIFT);
            assign code  = upper[QUANT_BITS] ? {QUANT_BITS{1'b1}} : upper[QUANT_BITS-1:0];
`else
            assign code = QUANT_BITS'(feature >> SHIFT);
`endif
        end
    endgenerate

endmodule

// File: rtl/lnet_input_packer.sv
// Packs NUM_FEATURES quantized features into one flat vector for the layer0 LUT array.
// Quantizer variant is chosen by LNET_PACK_ROUND_EN (see lnet_feature_quant).
module lnet_input_packer
    import lnet_pkg::*;
#(
    parameter int NUM_FEATURES = 64,
    parameter int FEAT_W       = LNET_FEAT_W,
    parameter int QUANT_BITS   = LNET_QUANT_BITS,
    parameter int OUT_W        = NUM_FEATURES * QUANT_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [FEAT_W-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             err
);

    localparam int              IDX_W    = $clog2(NUM_FEATURES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

    lnet_state_e           state;
    lnet_state_e           state_next;
    logic [IDX_W-1:0]      idx;
    logic [QUANT_BITS-1:0] code;
    logic                  accept;
    logic                  last_slot;

    lnet_feature_quant #(
        .FEAT_W     (FEAT_W),
        .QUANT_BITS (QUANT_BITS)
    ) u_quant (
        .feature (s_data),
        .code    (code)
    );

    assign s_ready   = (state == FILL);
    assign m_valid   = (state == HOLD);
    assign accept    = s_valid && s_ready;
    assign last_slot = (idx == LAST_IDX);

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (accept && last_slot) state_next = HOLD;
            HOLD:    if (m_ready) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // An early s_last drops the partial vector; a missing one on the final slot still delivers it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            m_data <= '0;
            err    <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < NUM_FEATURES; i++) begin
                if (idx == IDX_W'(i)) begin
                    m_data[i*QUANT_BITS +: QUANT_BITS] <= code;
                end
            end
            if (last_slot) begin
                idx <= '0;
                if (!s_last) err <= 1'b1;
            end else if (s_last) begin
                idx <= '0;
                err <= 1'b1;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lnet_input_packer.sv
// Self-checking bench for lnet_input_packer with a 3-feature, 2-bit configuration and a vector scoreboard.
module tb_lnet_input_packer;

    logic       clk;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;
    logic       m_valid;
    logic       m_ready;
    logic [5:0] m_data;
    logic       err;

    int         total_cnt;
    int         pass_cnt;
    logic [5:0] sb[$];
    bit         prev_hold;
    logic [5:0] prev_data;

    lnet_input_packer #(
        .NUM_FEATURES (3),
        .FEAT_W       (8),
        .QUANT_BITS   (2),
        .OUT_W        (6)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] model_q(input int d);
        int r;
`ifdef LNET_PACK_ROUND_EN
        r = (d + 32) / 64;
        if (r > 3) r = 3;
`else
        r = d / 64;
`endif
        return 2'(r);
    endfunction

    // Scoreboard consumer: every output handshake pops one expected vector; held vectors must not move.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                total_cnt++;
                if (m_valid !== 1'b1 || m_data !== prev_data)
                    $display("[TB] FAIL hold_stable: m_valid=%b m_data=%b required m_valid=1 m_data=%b", m_valid, m_data, prev_data);
                else
                    pass_cnt++;
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                total_cnt++;
                if (sb.size() == 0) begin
                    $display("[TB] FAIL sb_unexpected: got vector %b with no expected entry", m_data);
                end else begin
                    logic [5:0] exp_v;
                    exp_v = sb.pop_front();
                    if (m_data !== exp_v)
                        $display("[TB] FAIL sb_vector: m_data=%b required %b", m_data, exp_v);
                    else
                        pass_cnt++;
                end
            end
            prev_hold = (m_valid === 1'b1) && (m_ready === 1'b0);
            prev_data = m_data;
        end
    end

    // Holds one beat until accepted; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [7:0] d, input logic last);
        bit ok;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (s_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!ok) begin
            total_cnt++;
            $display("[TB] FAIL beat_timeout: s_ready stayed %b, required 1 within 200 cycles", s_ready);
        end
    endtask

    task automatic send_vector(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                               input logic [2:0] last_mask, input bit expect_out);
        if (expect_out) sb.push_back({model_q(d2), model_q(d1), model_q(d0)});
        send_beat(d0, last_mask[0]);
        send_beat(d1, last_mask[1]);
        send_beat(d2, last_mask[2]);
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        #2;
        total_cnt++;
        if ({m_valid, m_data, err} !== 8'b0)
            $display("[TB] FAIL reset_outputs: m_valid=%b m_data=%b err=%b required all 0", m_valid, m_data, err);
        else
            pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0)
            $display("[TB] FAIL reset_release: s_ready=%b m_valid=%b required 1/0", s_ready, m_valid);
        else
            pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        m_ready = 1'b1;
        send_vector(8'h00, 8'h40, 8'hC0, 3'b100, 1'b1);
        total_cnt++;
        if (m_valid !== 1'b1 || m_data !== 6'b110100 || err !== 1'b0 || s_ready !== 1'b0)
            $display("[TB] FAIL basic_out: m_valid=%b m_data=%b err=%b s_ready=%b required 1/110100/0/0",
                     m_valid, m_data, err, s_ready);
        else
            pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0)
            $display("[TB] FAIL basic_resume: s_ready=%b m_valid=%b required 1/0", s_ready, m_valid);
        else
            pass_cnt++;
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        send_vector(8'h00, 8'h40, 8'hC0, 3'b100, 1'b1);
        s_valid = 1'b1;
        s_data  = 8'hFF;
        s_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total_cnt++;
            if (m_valid !== 1'b1 || m_data !== 6'b110100 || s_ready !== 1'b0)
                $display("[TB] FAIL bp_hold cycle %0d: m_valid=%b m_data=%b s_ready=%b required 1/110100/0",
                         c, m_valid, m_data, s_ready);
            else
                pass_cnt++;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || err !== 1'b0)
            $display("[TB] FAIL bp_release: m_valid=%b s_ready=%b err=%b required 0/1/0", m_valid, s_ready, err);
        else
            pass_cnt++;
    endtask

    task automatic test_quant();
        logic [5:0] exp_v;
`ifdef LNET_PACK_ROUND_EN
        exp_v = 6'b011110;
`else
        exp_v = 6'b001101;
`endif
        m_ready = 1'b0;
        send_vector(8'h60, 8'hF0, 8'h3F, 3'b100, 1'b1);
        total_cnt++;
        if (m_valid !== 1'b1 || m_data !== exp_v)
            $display("[TB] FAIL quant_vector: m_valid=%b m_data=%b required 1/%b", m_valid, m_data, exp_v);
        else
            pass_cnt++;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_framing();
        m_ready = 1'b1;
        send_beat(8'h10, 1'b0);
        send_beat(8'h20, 1'b1);
        total_cnt++;
        if (err !== 1'b1 || m_valid !== 1'b0 || s_ready !== 1'b1)
            $display("[TB] FAIL early_last: err=%b m_valid=%b s_ready=%b required 1/0/1", err, m_valid, s_ready);
        else
            pass_cnt++;
        send_vector(8'hC0, 8'hC0, 8'hC0, 3'b100, 1'b1);
        total_cnt++;
        if (m_valid !== 1'b1 || m_data !== 6'b111111 || err !== 1'b1)
            $display("[TB] FAIL after_early_last: m_valid=%b m_data=%b err=%b required 1/111111/1",
                     m_valid, m_data, err);
        else
            pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midpacket();
        m_ready = 1'b1;
        send_beat(8'h80, 1'b0);
        send_beat(8'h80, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (m_valid !== 1'b0 || m_data !== 6'b0 || err !== 1'b0 || s_ready !== 1'b1)
            $display("[TB] FAIL async_reset: m_valid=%b m_data=%b err=%b s_ready=%b required 0/000000/0/1",
                     m_valid, m_data, err, s_ready);
        else
            pass_cnt++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_vector(8'h40, 8'h40, 8'h40, 3'b100, 1'b1);
        total_cnt++;
        if (m_valid !== 1'b1 || m_data !== 6'b010101)
            $display("[TB] FAIL post_reset_vector: m_valid=%b m_data=%b required 1/010101", m_valid, m_data);
        else
            pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_missing_last();
        m_ready = 1'b1;
        total_cnt++;
        if (err !== 1'b0)
            $display("[TB] FAIL err_clear_before: err=%b required 0", err);
        else
            pass_cnt++;
        send_vector(8'h80, 8'h40, 8'h00, 3'b000, 1'b1);
        total_cnt++;
        if (m_valid !== 1'b1 || err !== 1'b1 || m_data !== 6'b000110)
            $display("[TB] FAIL missing_last: m_valid=%b err=%b m_data=%b required 1/1/000110", m_valid, err, m_data);
        else
            pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        bit done;
        done = 1'b0;
        fork
            begin
                for (int v = 0; v < 24; v++) begin
                    logic [7:0] d0, d1, d2;
                    d0 = 8'($urandom_range(0, 255));
                    d1 = 8'($urandom_range(0, 255));
                    d2 = 8'($urandom_range(0, 255));
                    sb.push_back({model_q(d2), model_q(d1), model_q(d0)});
                    for (int b = 0; b < 3; b++) begin
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk);
                            #1;
                        end
                        send_beat(b == 0 ? d0 : (b == 1 ? d1 : d2), b == 2);
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    m_ready = 1'($urandom_range(0, 1));
                end
                m_ready = 1'b1;
            end
        join
        for (int c = 0; c < 50 && sb.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        total_cnt++;
        if (sb.size() != 0)
            $display("[TB] FAIL drain: %0d vectors still pending, required 0", sb.size());
        else
            pass_cnt++;
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        prev_hold = 1'b0;
        prev_data = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_quant();
        test_framing();
        test_reset_midpacket();
        test_missing_last();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
